// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    localparam logic [5:0] OP_J        = 6'h02;
    localparam logic [5:0] OP_HALT     = 6'h3F;
    localparam int         INSTR_BYTES = 4;

    // Primary opcode field of a 32-bit instruction word.
    function automatic logic [5:0] opcode(input logic [31:0] instr);
        return instr[31:26];
    endfunction

endpackage

// File: rtl/fetch_pc_next.sv
// Combinational next-PC selection: redirect, local jump, or sequential step.
module fetch_pc_next
    import fetch_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_addr,
    output logic [31:0] pc_next,
    output logic        is_jump,
    output logic        is_halt
);

    logic [31:0] pc_plus4;

    assign pc_plus4 = pc + 32'(INSTR_BYTES);
    assign is_jump  = (opcode(imem_instr) == OP_J);
    assign is_halt  = (opcode(imem_instr) == OP_HALT);

    // Redirect beats a jump; a jump keeps the upper nibble of the sequential PC.
    always_comb begin
        pc_next = pc_plus4;
        if (redirect_valid) begin
            pc_next = redirect_addr;
        end else if (is_jump) begin
            pc_next = {pc_plus4[31:28], imem_instr[25:0], 2'b00};
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives the instruction memory and
// presents fetched words to decode over a valid/ready handshake.
// Optional feature macro: FETCH_PERF_CNT_EN enables the accepted-instruction
// counter on fetch_count; without it fetch_count is tied to zero.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0,
    parameter logic [31:0] MEM_BYTES = 32'd256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_addr,
    output logic        halted,
    output logic        fault,
    output logic [31:0] fetch_count
);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_instr_q, out_instr_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic        halted_q, halted_d;
    logic        fault_q, fault_d;

    logic [31:0] pc_next;
    logic        is_halt;
    logic        jump_flag_unused;
    logic        cap;
    logic        pc_illegal;

    fetch_pc_next u_pc_next (
        .pc             (pc_q),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .pc_next        (pc_next),
        .is_jump        (jump_flag_unused),
        .is_halt        (is_halt)
    );

    // The jump target is already folded into pc_next; the flag is only a debug tap.
    assign cap        = !out_valid_q || out_ready;
    assign pc_illegal = (pc_q[1:0] != 2'b00) || (pc_q >= MEM_BYTES);

    // Next-state and next-output computation for the fetch FSM.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_pc_d    = out_pc_q;
        case (state_q)
            ST_IDLE: begin
                if (redirect_valid) begin
                    state_d = ST_RUN;
                    pc_d    = redirect_addr;
                end else if (start) begin
                    state_d = ST_RUN;
                    pc_d    = RESET_PC;
                end
            end
            ST_RUN: begin
                if (redirect_valid) begin
                    pc_d        = pc_next;
                    out_valid_d = 1'b0;
                end else if (pc_illegal) begin
                    state_d     = ST_ERR;
                    out_valid_d = 1'b0;
                end else if (cap && is_halt) begin
                    state_d     = ST_HALT;
                    out_valid_d = 1'b0;
                end else if (cap) begin
                    out_instr_d = imem_instr;
                    out_pc_d    = pc_q;
                    out_valid_d = 1'b1;
                    pc_d        = pc_next;
                end
            end
            ST_HALT: begin
                if (redirect_valid) begin
                    state_d = ST_RUN;
                    pc_d    = redirect_addr;
                end
            end
            ST_ERR: begin
                state_d = ST_ERR;
            end
            default: begin
                state_d = ST_ERR;
            end
        endcase
        halted_d = (state_d == ST_HALT);
        fault_d  = (state_d == ST_ERR);
    end

    // FSM state, PC and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            pc_q        <= RESET_PC;
            out_valid_q <= 1'b0;
            out_instr_q <= 32'h0;
            out_pc_q    <= 32'h0;
            halted_q    <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_pc_q    <= out_pc_d;
            halted_q    <= halted_d;
            fault_q     <= fault_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] cnt_q, cnt_d;

    assign cnt_d = cnt_q + {31'd0, (out_valid_q && out_ready)};

    // Count every completed handshake with decode; wraps naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= 32'h0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign fetch_count = cnt_q;
`else
    assign fetch_count = 32'h0;
`endif

    assign imem_addr = pc_q;
    assign out_valid = out_valid_q;
    assign out_instr = out_instr_q;
    assign out_pc    = out_pc_q;
    assign halted    = halted_q;
    assign fault     = fault_q;

endmodule
